serial_add_ctrl: RTL and testbench

//   Bit-serial adder controller: sequences one shared 1-bit fulladder instance
//   (A,B,Cin -> S,Cout) over WIDTH clock cycles to add two WIDTH-bit operands.

---
 rtl/serial_add_ctrl.sv | 139 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller
// One shared full adder, one bit slice per clock, LSB first.
module serial_add_fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_s;
  logic             w_c;
  logic             w_last;
  logic             w_load;
  logic             w_run;
  logic [WIDTH-1:0] w_sum_fin;

  serial_add_fa u_fa (
    .i_a (r_a_sr[0]),
    .i_b (r_b_sr[0]),
    .i_c (r_carry),
    .o_s (w_s),
    .o_c (w_c)
  );

  assign w_run  = (r_state == S_RUN);
  assign w_last = (r_cnt == CW'(WIDTH - 1));
  assign w_load = start && (r_state != S_RUN);

  // Partial sum: bits already produced sit below the incoming slice.
  if (WIDTH == 1) begin : g_w1
    assign w_sum_fin = w_s;
  end else begin : g_wn
    logic [WIDTH-2:0] r_sum_sr;

    // Shift each produced sum bit in from the top.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sum_sr <= '0;
      end else if (w_run) begin
        r_sum_sr <= w_sum_fin[WIDTH-1:1];
      end
    end

    assign w_sum_fin = {w_s, r_sum_sr};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: start only honoured outside RUN.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = start ? S_RUN : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, bit-slice stepping and result commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_load) begin
      r_a_sr  <= a;
      r_b_sr  <= b;
      r_carry <= cin;
      r_cnt   <= '0;
    end else if (w_run) begin
      r_a_sr  <= r_a_sr >> 1;
      r_b_sr  <= r_b_sr >> 1;
      r_carry <= w_c;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_sum  <= w_sum_fin;
        r_cout <= w_c;
      end
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: scoreboard bench for serial_add_ctrl
// Covers WIDTH=8 directed, WIDTH=3 and WIDTH=1 exhaustive.
module tb_serial_add_ctrl;
  typedef struct {
    logic [64:0] res;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  exp_t q8[$];
  exp_t q3[$];
  exp_t q1[$];

  logic       s8, c8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       s3, c3, busy3, done3, cout3;
  logic [2:0] a3, b3, sum3;
  logic       s1, c1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  serial_add_ctrl #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8),
    .cin(c8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );
  serial_add_ctrl #(.WIDTH(3)) u_w3 (
    .clk(clk), .rst_n(rst_n), .start(s3), .a(a3), .b(b3),
    .cin(c3), .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
  );
  serial_add_ctrl #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .start(s1), .a(a1), .b(b1),
    .cin(c1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [64:0] act,
                       input logic [64:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Monitors: pop on every done pulse and compare result and timing.
  always @(negedge clk) begin
    if (rst_n && done8) begin
      if (q8.size() == 0) begin
        check("w8_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        check("w8_result", {cout8, sum8}, e.res);
        check("w8_latency", cyc, e.cyc);
      end
      check("w8_busy_with_done", busy8, 0);
    end
  end

  always @(negedge clk) begin
    if (rst_n && done3) begin
      if (q3.size() == 0) begin
        check("w3_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q3.pop_front();
        check("w3_result", {cout3, sum3}, e.res);
        check("w3_latency", cyc, e.cyc);
      end
      check("w3_busy_with_done", busy3, 0);
    end
  end

  always @(negedge clk) begin
    if (rst_n && done1) begin
      if (q1.size() == 0) begin
        check("w1_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("w1_result", {cout1, sum1}, e.res);
        check("w1_latency", cyc, e.cyc);
      end
      check("w1_busy_with_done", busy1, 0);
    end
  end

  // Issue tasks: called at a negedge; wait for IDLE/DONE, then start.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic [8:0] exp);
    int n = 0;
    exp_t e;
    while (busy8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy8) check("w8_wait_idle_timeout", 1, 0);
    a8 = a; b8 = b; c8 = c; s8 = 1'b1;
    e.res = 65'(exp);
    e.cyc = cyc + 1 + 8;
    q8.push_back(e);
    @(negedge clk);
    s8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
  endtask

  task automatic issue3(input logic [2:0] a, input logic [2:0] b,
                        input logic c);
    int n = 0;
    exp_t e;
    while (busy3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy3) check("w3_wait_idle_timeout", 1, 0);
    a3 = a; b3 = b; c3 = c; s3 = 1'b1;
    e.res = 65'(int'(a) + int'(b) + int'(c));
    e.cyc = cyc + 1 + 3;
    q3.push_back(e);
    @(negedge clk);
    s3 = 1'b0;
    a3 = 3'($urandom); b3 = 3'($urandom); c3 = 1'($urandom);
  endtask

  task automatic issue1(input logic a, input logic b, input logic c);
    int n = 0;
    exp_t e;
    while (busy1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy1) check("w1_wait_idle_timeout", 1, 0);
    a1 = a; b1 = b; c1 = c; s1 = 1'b1;
    e.res = 65'(int'(a) + int'(b) + int'(c));
    e.cyc = cyc + 1 + 1;
    q1.push_back(e);
    @(negedge clk);
    s1 = 1'b0;
    a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
  endtask

  logic [7:0] vec_a[4] = '{8'h5A, 8'hFF, 8'hFF, 8'h00};
  logic [7:0] vec_b[4] = '{8'h33, 8'h01, 8'hFF, 8'h00};
  logic       vec_c[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [8:0] vec_e[4] = '{9'h08D, 9'h100, 9'h1FF, 9'h001};

  initial begin
    int n;
    s8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'b1;
    s3 = 1'b1; a3 = 3'($urandom); b3 = 3'($urandom); c3 = 1'b1;
    s1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    #23;
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_sum_cout", {cout8, sum8}, 0);
    check("rst_w3_w1", {busy3, done3, busy1, done1}, 0);

    @(negedge clk);
    s8 = 1'b0; s3 = 1'b0; s1 = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy_done", {busy8, done8}, 0);
    check("idle_sum_cout", {cout8, sum8}, 0);

    for (int i = 0; i < 4; i++) begin
      issue8(vec_a[i], vec_b[i], vec_c[i], vec_e[i]);
    end

    issue8(8'h12, 8'h34, 1'b0, 9'h046);
    for (int i = 0; i < 3; i++) begin
      s8 = 1'b1;
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      check("run_busy", busy8, 1);
      check("run_sum_hold", {cout8, sum8}, 9'h001);
      @(negedge clk);
    end
    s8 = 1'b0;
    issue8(8'h80, 8'h80, 1'b0, 9'h100);
    issue8(8'h7F, 8'h01, 1'b1, 9'h081);

    issue8(8'hFF, 8'hFF, 1'b1, 9'h1FF);
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    q8.delete();
    #1;
    check("midrst_busy_done", {busy8, done8}, 0);
    check("midrst_sum_cout", {cout8, sum8}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue8(8'h10, 8'h20, 1'b0, 9'h030);

    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        for (int c = 0; c < 2; c++)
          issue3(3'(a), 3'(b), 1'(c));

    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < 2; c++)
          issue1(1'(a), 1'(b), 1'(c));

    n = 0;
    while ((q8.size() + q3.size() + q1.size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_w8", q8.size(), 0);
    check("drain_w3", q3.size(), 0);
    check("drain_w1", q1.size(), 0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
